// File: rtl/fsm_share_arbiter_if.sv
// rtl/fsm_share_arbiter_if.sv - requester and shared-detector signals of fsm_share_arbiter
interface fsm_share_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] a_in;
    logic [N_REQ-1:0] b_in;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             det_a;
    logic             det_b;
    logic             det_rst;
    logic             det_q;
    logic [N_REQ-1:0] q_out;

    // Stimulus/detector side.
    modport master (
        output req, a_in, b_in, det_q,
        input  gnt, gnt_id, busy, det_a, det_b, det_rst, q_out
    );

    // Arbiter side.
    modport slave (
        input  req, a_in, b_in, det_q,
        output gnt, gnt_id, busy, det_a, det_b, det_rst, q_out
    );
endinterface

// File: rtl/fsm_share_arbiter.sv
// rtl/fsm_share_arbiter.sv - round-robin sharing of one A/B detector among N_REQ requesters
// Optional tenure timeout compiled in with FSM_SHARE_TIMEOUT_EN.
module fsm_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input logic                clk,
    input logic                reset,
    fsm_share_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FLUSH   = 2'd1;
    localparam logic [1:0] GRANT   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2) begin : g_bad_param
        $error("fsm_share_arbiter: N_REQ must be 2..16 and MAX_HOLD at least 2");
    end

    logic [1:0]       state;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic [N_REQ-1:0] sel_mask;
    logic             any_req;
    logic             timeout;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = rr_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (bus.req[ID_W'(idx)]) begin
                winner = ID_W'(idx);
            end
        end
    end

    assign any_req = |bus.req;

    always_comb begin
        sel_mask         = '0;
        sel_mask[gnt_id] = 1'b1;
    end

`ifdef FSM_SHARE_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_sat;

    assign hold_sat = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    // Only preempt when someone else is actually waiting.
    assign timeout  = hold_sat && (|(bus.req & ~sel_mask));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == FLUSH) begin
            hold_cnt <= '0;
        end else if (state == GRANT && !hold_sat) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt_id <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id <= winner;
                        state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= GRANT;
                end
                GRANT: begin
                    if (!bus.req[gnt_id] || timeout) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Only the granted requester ever sees or drives the detector.
    always_comb begin
        bus.gnt   = '0;
        bus.q_out = '0;
        bus.det_a = 1'b0;
        bus.det_b = 1'b0;
        if (state == GRANT) begin
            bus.gnt           = sel_mask;
            bus.det_a         = bus.a_in[gnt_id];
            bus.det_b         = bus.b_in[gnt_id];
            bus.q_out[gnt_id] = bus.det_q;
        end
    end

    assign bus.gnt_id  = gnt_id;
    assign bus.busy    = (state != IDLE);
    assign bus.det_rst = reset | (state == FLUSH);
endmodule

// File: tb/tb_fsm_share_arbiter.sv
// tb/tb_fsm_share_arbiter.sv - scoreboard bench for fsm_share_arbiter with a stand-in A/B detector
module tb_fsm_share_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fsm_share_arbiter_if #(.N_REQ(N)) bus ();

    fsm_share_arbiter #(.N_REQ(N), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Moore detector: A, then B on two consecutive cycles, raises Q until B drops.
    logic [1:0] dstate;
    always_ff @(posedge clk) begin
        if (bus.det_rst) begin
            dstate <= 2'd0;
        end else begin
            case (dstate)
                2'd0:    dstate <= bus.det_a ? 2'd1 : 2'd0;
                2'd1:    dstate <= bus.det_b ? 2'd2 : (bus.det_a ? 2'd1 : 2'd0);
                2'd2:    dstate <= bus.det_b ? 2'd3 : 2'd0;
                default: dstate <= bus.det_b ? 2'd3 : 2'd0;
            endcase
        end
    end
    assign bus.det_q = (dstate == 2'd3);

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] gid;
        logic       busy;
        logic       drst;
        logic       da;
        logic       db;
        logic [3:0] q;
    } exp_t;

    exp_t  expq[$];
    string nmq[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic v(input string nm, input logic r, input logic [3:0] rq, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] eg, input logic [1:0] ei,
                     input logic ebusy, input logic edrst, input logic eda, input logic edb,
                     input logic [3:0] eq);
        @(posedge clk);
        #1;
        reset    = r;
        bus.req  = rq;
        bus.a_in = a;
        bus.b_in = b;
        expq.push_back(exp_t'{eg, ei, ebusy, edrst, eda, edb, eq});
        nmq.push_back(nm);
    endtask

    always @(negedge clk) begin
        exp_t  act;
        exp_t  e;
        string nm;
        act = exp_t'{bus.gnt, bus.gnt_id, bus.busy, bus.det_rst, bus.det_a, bus.det_b, bus.q_out};
        checks++;
        if ($countones(bus.gnt) > 1) begin
            failures++;
            $display("FAIL onehot: gnt=%b, required zero or one-hot", bus.gnt);
        end
        if (expq.size() > 0) begin
            e  = expq.pop_front();
            nm = nmq.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: actual gnt=%b id=%0d busy=%b drst=%b da=%b db=%b q=%b required gnt=%b id=%0d busy=%b drst=%b da=%b db=%b q=%b",
                         nm, act.gnt, act.gid, act.busy, act.drst, act.da, act.db, act.q,
                         e.gnt, e.gid, e.busy, e.drst, e.da, e.db, e.q);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] w;
        logic [1:0] prev;
        logic [3:0] one;
        reset    = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;

        v("rst",      1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
        v("idle",     0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        // single request
        v("s_idle",   0, 4'b0100, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        v("s_flush",  0, 4'b0100, 0, 0, 4'b0000, 2, 1, 1, 0, 0, 0);
        v("s_g1",     0, 4'b0100, 0, 0, 4'b0100, 2, 1, 0, 0, 0, 0);
        v("s_g2",     0, 4'b0100, 0, 0, 4'b0100, 2, 1, 0, 0, 0, 0);
        v("s_g3",     0, 4'b0000, 0, 0, 4'b0100, 2, 1, 0, 0, 0, 0);
        v("s_rel",    0, 4'b0000, 0, 0, 4'b0000, 2, 1, 0, 0, 0, 0);
        v("s_idle2",  0, 4'b0000, 0, 0, 4'b0000, 2, 0, 0, 0, 0, 0);
        // wrap: rr_ptr is 3 here
        v("w_idle",   0, 4'b1001, 0, 0, 4'b0000, 2, 0, 0, 0, 0, 0);
        v("w_flush",  0, 4'b1001, 0, 0, 4'b0000, 3, 1, 1, 0, 0, 0);
        v("w_g3",     0, 4'b0001, 0, 0, 4'b1000, 3, 1, 0, 0, 0, 0);
        v("w_rel",    0, 4'b0001, 0, 0, 4'b0000, 3, 1, 0, 0, 0, 0);
        v("w_idle2",  0, 4'b0001, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0);
        v("w_flush0", 0, 4'b0001, 0, 0, 4'b0000, 0, 1, 1, 0, 0, 0);
        v("w_g0",     0, 4'b0000, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
        v("w_rel0",   0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
        // round robin from reset: 0,1,2,3,0
        v("rst2",     1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            w    = 2'(k % 4);
            prev = (k == 0) ? 2'd0 : 2'((k - 1) % 4);
            one  = 4'b0001 << w;
            v("rr_idle",  0, 4'b1111,        4'b1111, 4'b1111, 4'b0000, prev, 0, 0, 0, 0, 0);
            v("rr_flush", 0, 4'b1111,        4'b1111, 4'b1111, 4'b0000, w,    1, 1, 0, 0, 0);
            v("rr_g1",    0, 4'b1111,        4'b1111, 4'b1111, one,     w,    1, 0, 1, 1, 0);
            v("rr_g2",    0, 4'b1111,        4'b1111, 4'b1111, one,     w,    1, 0, 1, 1, 0);
            v("rr_g3",    0, 4'b1111 & ~one, 4'b1111, 4'b1111, one,     w,    1, 0, 1, 1, 0);
            v("rr_rel",   0, 4'b1111,        4'b1111, 4'b1111, 4'b0000, w,    1, 0, 0, 0, 0);
        end
        // detection routing through requester 1 (rr_ptr is 1)
        v("d_idle",   0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
        v("d_flush",  0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 0, 0, 4'b0000);
        v("d_g_a",    0, 4'b0010, 4'b0011, 4'b0000, 4'b0010, 1, 1, 0, 1, 0, 4'b0000);
        v("d_g_b",    0, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 1, 1, 0, 0, 1, 4'b0000);
        v("d_g_b2",   0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1, 1, 0, 0, 1, 4'b0000);
        v("d_g_q",    0, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 1, 1, 0, 0, 1, 4'b0010);
        v("d_g_drop", 0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1, 1, 0, 0, 1, 4'b0010);
        v("d_rel",    0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 1, 0, 0, 0, 4'b0000);
        v("d_idle2",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
        // hold/timeout with requesters 0 and 1 (rr_ptr is 2)
        v("t_idle",   0, 4'b0011, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        v("t_flush",  0, 4'b0011, 0, 0, 4'b0000, 0, 1, 1, 0, 0, 0);
`ifdef FSM_SHARE_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            v("t_hold", 0, 4'b0011, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
        end
        v("t_rel",    0, 4'b0011, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
        v("t_idle2",  0, 4'b0011, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
`else
        for (int k = 0; k < 50; k++) begin
            v("t_hold", 0, 4'b0011, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
        end
        v("t_last",   0, 4'b0010, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
        v("t_rel",    0, 4'b0010, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
        v("t_idle2",  0, 4'b0010, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
`endif
        v("t_flush1", 0, 4'b0010, 0, 0, 4'b0000, 1, 1, 1, 0, 0, 0);
        v("t_g1",     0, 4'b0010, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
        // reset in the middle of a GRANT tenure
        v("r_assert", 1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0, 0, 1, 0, 0, 0);
        v("r_idle",   0, 4'b0010, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        v("r_flush",  0, 4'b0010, 0, 0, 4'b0000, 1, 1, 1, 0, 0, 0);
        v("r_g",      0, 4'b0010, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
        v("r_drop",   0, 4'b0000, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
        v("r_rel",    0, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsm_share_arbiter.md
Name: fsm_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one A/B sequence-detector FSM (Moore, output Q) among N_REQ requesters.
- On each handover it clears the shared detector to its idle state, then routes the winner's A/B inputs to the detector and the detector's Q back to the winner.
- Sits between requester-side stimulus sources and the single detector instance.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 16, maximum GRANT cycles per tenure when the timeout feature is compiled in; legal range ≥ 2.
- ID_W, $clog2(N_REQ), width of the requester index (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request; level, held while access is wanted.
- a_in  in  N_REQ  per-requester A stimulus.
- b_in  in  N_REQ  per-requester B stimulus.
- gnt  out  N_REQ  one-hot grant; all zeros when no tenure is active.
- gnt_id  out  ID_W  index of the current or last winner.
- busy  out  1  high in FLUSH, GRANT and RELEASE.
- det_a  out  1  A input to the shared detector.
- det_b  out  1  B input to the shared detector.
- det_rst  out  1  reset to the shared detector; high while reset is asserted and during FLUSH.
- det_q  in  1  Q output from the shared detector.
- q_out  out  N_REQ  det_q routed to the granted requester; 0 elsewhere.

Behaviour:
- Registered state: state, gnt_id, rr_ptr (ID_W), hold_cnt.
- Reset values: state=IDLE, gnt_id=0, rr_ptr=0, hold_cnt=0.
- Reset output values: gnt=0, busy=0, det_a=0, det_b=0, q_out=0, det_rst=1.
- All outputs decode from registers and req/a_in/b_in/det_q only. No output depends combinationally on reset except det_rst.
- IDLE
  - If any req bit is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Register the winner in gnt_id and go to FLUSH. Otherwise stay in IDLE.
- FLUSH (1 cycle)
  - det_rst=1, gnt=0, det_a=det_b=0, hold_cnt cleared. Go to GRANT.
  - Winner is committed even if its req drops during FLUSH; it is then released after one GRANT cycle.
- GRANT
  - gnt[gnt_id]=1, det_a=a_in[gnt_id], det_b=b_in[gnt_id], q_out[gnt_id]=det_q.
  - hold_cnt increments, saturating at MAX_HOLD-1.
  - Exit to RELEASE when req[gnt_id]==0, or on timeout (see Optional Feature).
- RELEASE (1 cycle)
  - gnt=0, det_a=det_b=0, q_out=0.
  - rr_ptr <= (gnt_id+1) mod N_REQ, with explicit wrap when gnt_id==N_REQ-1. Go to IDLE.
- Latency
  - req sampled high in IDLE at edge t → gnt high for cycles t+2 onward.
  - Minimum gap between consecutive tenures is 3 cycles of gnt=0 (RELEASE, IDLE, FLUSH).
- Detector Q visibility
  - The detector is Moore, so q_out reflects the state the detector entered on the previous edge.
  - q_out is never asserted in the first GRANT cycle, because the detector was cleared in FLUSH.
- Simultaneous requests are resolved purely by rr_ptr; there is no fixed priority.
- Requests from non-granted requesters are ignored until the next IDLE; a_in/b_in of non-granted requesters are never routed.
- Reset mid-tenure: all outputs go immediately to their reset values, det_rst asserts asynchronously, rr_ptr returns to 0.

Optional Feature:
- Macro: FSM_SHARE_TIMEOUT_EN.
- Defined
  - In GRANT, when hold_cnt==MAX_HOLD-1 and any other req bit is set, exit to RELEASE regardless of req[gnt_id].
  - If no other requester is waiting, the tenure continues and hold_cnt stays saturated.
- Undefined
  - No timeout; a tenure ends only when req[gnt_id] drops.
  - hold_cnt logic may be omitted.

Test Plan:
- Single request: reset, then req=4'b0100 at cycle 0 → gnt=4'b0100, gnt_id=2 from cycle 2; det_rst=1 in cycle 1; drop req → gnt=0 next cycle; rr_ptr=3 after RELEASE.
- Round-robin order: req=4'b1111 held, each winner drops req after 3 GRANT cycles → grant order 0,1,2,3,0; gnt always one-hot or zero.
- Wrap: rr_ptr=3 with req=4'b1001 → requester 3 wins first, then 0 on the next tenure.
- Detection routing: requester 1 granted, a_in[1]=1 for one cycle, then b_in[1]=1 held → q_out[1] rises two cycles after b_in[1] rises; q_out[0,2,3] stay 0; toggling a_in[0] has no effect on det_a.
- Timeout (macro defined, MAX_HOLD=4): req[0] and req[1] both held → gnt[0] for exactly 4 cycles, then RELEASE, then gnt[1]. With the macro undefined, gnt[0] persists for 50 cycles.
- Reset mid-GRANT: assert reset in GRANT → gnt=0, q_out=0, busy=0, det_rst=1 immediately; after release with req=4'b0010 held, gnt[1] asserts 2 cycles later.
